// File: rtl/counter_pkg.sv
// Shared types and default parameter values for the up/down modulo counter.
// Consumers: updown_mod_counter, sat_event_counter.
package counter_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_mode_e;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_WRAP_W = 8;

endpackage : counter_pkg

// File: rtl/sat_event_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
// Synchronous active-high reset clears the count.
module sat_event_counter
  import counter_pkg::*;
#(
  parameter int unsigned W = DEF_WRAP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: next-state logic assigns a default before any branch, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : sat_event_counter

// File: rtl/updown_mod_counter.sv
// Loadable up/down counter over 0..MAX_VAL with terminal-count pulse and boundary-event tally.
// Define COUNTER_SATURATE_EN to hold at the range limits instead of wrapping.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter int unsigned      WRAP_W  = DEF_WRAP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic              mode,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  dout,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              load_err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_LIMIT_NEXT   = MAX_VAL;
  localparam logic [WIDTH-1:0] DOWN_LIMIT_NEXT = '0;
`else
  localparam logic [WIDTH-1:0] UP_LIMIT_NEXT   = '0;
  localparam logic [WIDTH-1:0] DOWN_LIMIT_NEXT = MAX_VAL;
`endif

  cnt_mode_e        dir;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             tc_q, tc_d;
  logic             load_err_q, load_err_d;
  logic             boundary;

  assign dir = cnt_mode_e'(mode);

  always_comb begin
    dout_d     = dout_q;
    load_err_d = 1'b0;
    boundary   = 1'b0;
    if (load) begin
      // Out-of-range loads clamp to the top of the range and flag the error.
      if (data_in > MAX_VAL) begin
        dout_d     = MAX_VAL;
        load_err_d = 1'b1;
      end else begin
        dout_d = data_in;
      end
    end else if (en) begin
      if (dir == CNT_UP) begin
        if (dout_q == MAX_VAL) begin
          boundary = 1'b1;
          dout_d   = UP_LIMIT_NEXT;
        end else begin
          dout_d = dout_q + ONE;
        end
      end else begin
        if (dout_q == '0) begin
          boundary = 1'b1;
          dout_d   = DOWN_LIMIT_NEXT;
        end else begin
          dout_d = dout_q - ONE;
        end
      end
    end
    tc_d = boundary;
  end

  // NOTE: only control/data flops here; reset clears every one because all are architecturally visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q     <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  // Reset dominates inside the tally too, so a boundary on a reset edge is not counted.
  sat_event_counter #(
    .W (WRAP_W)
  ) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .inc (boundary),
    .cnt (wrap_cnt)
  );

  assign dout     = dout_q;
  assign tc       = tc_q;
  assign load_err = load_err_q;

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter (WIDTH=4, MAX_VAL=9, WRAP_W=3), both build variants.
// Driver pushes hand-computed expectations; an independent monitor pops and compares each cycle.
module tb_updown_mod_counter;
  import counter_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned WW = 3;
  localparam logic [W-1:0] MAXV = 4'd9;

`ifdef COUNTER_SATURATE_EN
  localparam logic [W-1:0] UP_BND   = 4'd9;
  localparam logic [W-1:0] DOWN_BND = 4'd0;
  localparam logic         B2B_MODE = 1'b1;
`else
  localparam logic [W-1:0] UP_BND   = 4'd0;
  localparam logic [W-1:0] DOWN_BND = 4'd9;
  localparam logic         B2B_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, load, en, mode;
  logic [W-1:0]  data_in;
  logic [W-1:0]  dout;
  logic          tc;
  logic [WW-1:0] wrap_cnt;
  logic          load_err;

  typedef struct packed {
    int            idx;
    logic [W-1:0]  dout;
    logic          tc;
    logic [WW-1:0] wrap;
    logic          lerr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_idx = 0;

  updown_mod_counter #(
    .WIDTH   (W),
    .MAX_VAL (MAXV),
    .WRAP_W  (WW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .en       (en),
    .mode     (mode),
    .data_in  (data_in),
    .dout     (dout),
    .tc       (tc),
    .wrap_cnt (wrap_cnt),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL step%0d %s: got %0d expected %0d", idx, name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the state expected after the next edge.
  task automatic step(input logic r, input logic l, input logic e, input logic m,
                      input logic [W-1:0] din, input logic [W-1:0] xd, input logic xt,
                      input logic [WW-1:0] xw, input logic xl);
    exp_t x;
    @(negedge clk);
    rst     = r;
    load    = l;
    en      = e;
    mode    = m;
    data_in = din;
    x.idx   = step_idx;
    x.dout  = xd;
    x.tc    = xt;
    x.wrap  = xw;
    x.lerr  = xl;
    sb_q.push_back(x);
    step_idx++;
  endtask

  // Monitor: outputs are registered, so each pushed expectation is due right after the next posedge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("dout",     e.idx, 32'(dout),     32'(e.dout));
        check("tc",       e.idx, 32'(tc),       32'(e.tc));
        check("wrap_cnt", e.idx, 32'(wrap_cnt), 32'(e.wrap));
        check("load_err", e.idx, 32'(load_err), 32'(e.lerr));
      end
    end
  end

  initial begin
    logic [W-1:0]  md;
    logic [WW-1:0] mw;
    logic          mt;
    rst = 1'b1; load = 1'b0; en = 1'b0; mode = 1'b0; data_in = '0;

    //   rst  load en  mode      din    dout      tc   wrap  lerr
    step(1'b1, 1'b1, 1'b1, CNT_UP,   4'd5, 4'd0,     1'b0, 3'd0, 1'b0); // reset beats load/en
    step(1'b0, 1'b1, 1'b0, CNT_UP,   4'd7, 4'd7,     1'b0, 3'd0, 1'b0); // load 7
    step(1'b0, 1'b0, 1'b0, CNT_UP,   4'd0, 4'd7,     1'b0, 3'd0, 1'b0); // idle holds
    step(1'b0, 1'b1, 1'b0, CNT_UP,   4'd8, 4'd8,     1'b0, 3'd0, 1'b0); // load 8
    step(1'b0, 1'b0, 1'b1, CNT_UP,   4'd0, 4'd9,     1'b0, 3'd0, 1'b0); // 8 -> 9
    step(1'b0, 1'b0, 1'b1, CNT_UP,   4'd0, UP_BND,   1'b1, 3'd1, 1'b0); // up boundary
    step(1'b0, 1'b0, 1'b0, CNT_UP,   4'd0, UP_BND,   1'b0, 3'd1, 1'b0); // tc is one cycle
    step(1'b1, 1'b0, 1'b0, CNT_UP,   4'd0, 4'd0,     1'b0, 3'd0, 1'b0); // reset
    step(1'b0, 1'b1, 1'b0, CNT_DOWN, 4'd0, 4'd0,     1'b0, 3'd0, 1'b0); // load 0
    step(1'b0, 1'b0, 1'b1, CNT_DOWN, 4'd0, DOWN_BND, 1'b1, 3'd1, 1'b0); // down boundary
    step(1'b0, 1'b1, 1'b0, CNT_DOWN, 4'd5, 4'd5,     1'b0, 3'd1, 1'b0); // load 5
    step(1'b0, 1'b0, 1'b1, CNT_UP,   4'd0, 4'd6,     1'b0, 3'd1, 1'b0); // up
    step(1'b0, 1'b0, 1'b1, CNT_DOWN, 4'd0, 4'd5,     1'b0, 3'd1, 1'b0); // immediate reversal
    step(1'b0, 1'b0, 1'b1, CNT_DOWN, 4'd0, 4'd4,     1'b0, 3'd1, 1'b0); // down
    step(1'b0, 1'b1, 1'b0, CNT_UP,   4'd12, 4'd9,    1'b0, 3'd1, 1'b1); // out-of-range load
    step(1'b0, 1'b0, 1'b0, CNT_UP,   4'd0, 4'd9,     1'b0, 3'd1, 1'b0); // load_err one cycle
    step(1'b0, 1'b1, 1'b1, CNT_UP,   4'd9, 4'd9,     1'b0, 3'd1, 1'b0); // load beats boundary
    step(1'b0, 1'b0, 1'b0, CNT_UP,   4'd0, 4'd9,     1'b0, 3'd1, 1'b0); // idle
    step(1'b0, 1'b0, 1'b1, CNT_UP,   4'd0, UP_BND,   1'b1, 3'd2, 1'b0); // boundary
    step(1'b0, 1'b0, 1'b1, B2B_MODE, 4'd0, 4'd9,     1'b1, 3'd3, 1'b0); // back-to-back boundary
    step(1'b0, 1'b1, 1'b0, CNT_UP,   4'd9, 4'd9,     1'b0, 3'd3, 1'b0); // load 9
    step(1'b1, 1'b0, 1'b1, CNT_UP,   4'd0, 4'd0,     1'b0, 3'd0, 1'b0); // reset on boundary edge
    step(1'b0, 1'b0, 1'b1, CNT_UP,   4'd0, 4'd1,     1'b0, 3'd0, 1'b0); // first edge after reset
    step(1'b1, 1'b0, 1'b0, CNT_UP,   4'd0, 4'd0,     1'b0, 3'd0, 1'b0); // reset

    // Continuous up-count across many boundary events: the tally must stick at 7.
    md = 4'd0;
    mw = 3'd0;
    for (int i = 0; i < 100; i++) begin
      if (md == MAXV) begin
        mt = 1'b1;
        mw = (mw == 3'd7) ? 3'd7 : mw + 3'd1;
`ifdef COUNTER_SATURATE_EN
        md = MAXV;
`else
        md = 4'd0;
`endif
      end else begin
        mt = 1'b0;
        md = md + 4'd1;
      end
      step(1'b0, 1'b0, 1'b1, CNT_UP, 4'd0, md, mt, mw, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, CNT_UP, 4'd0, md, 1'b0, 3'd7, 1'b0); // hold, tally saturated

    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
    #2;
    check("scoreboard_drained", step_idx, 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_updown_mod_counter

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: counter width, legal range 2..32.
REQ-002 The block SHALL have parameter MAX_VAL, default 2**WIDTH-1: terminal value; the count range is 0..MAX_VAL; MAX_VAL must be at least 1.
REQ-003 The block SHALL have parameter WRAP_W, default 8: width of the wrap-event counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port load, input, 1 bit: load data_in into the count.
REQ-007 The block SHALL have port en, input, 1 bit: count enable.
REQ-008 The block SHALL have port mode, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-009 The block SHALL have port data_in, input, WIDTH bits: load value.
REQ-010 The block SHALL have port dout, output, WIDTH bits: registered count.
REQ-011 The block SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-012 The block SHALL have port wrap_cnt, output, WRAP_W bits: number of boundary events since reset.
REQ-013 The block SHALL have port load_err, output, 1 bit: registered one-cycle pulse for an out-of-range load.

Function
REQ-014 Priority at each posedge SHALL be rst > load > en; when none is asserted, all state SHALL hold and tc and load_err SHALL be 0.
REQ-015 On load with data_in <= MAX_VAL, dout SHALL equal data_in after the edge and load_err SHALL be 0.
REQ-016 On load with data_in > MAX_VAL, dout SHALL become MAX_VAL and load_err SHALL be 1 for exactly one cycle.
REQ-017 A load SHALL never assert tc or change wrap_cnt, even when en is also high.
REQ-018 With en=1, mode=1 and dout < MAX_VAL, dout SHALL increment by 1; with mode=0 and dout > 0, dout SHALL decrement by 1.
REQ-019 A boundary event SHALL be either: en=1, mode=1 at dout==MAX_VAL; or en=1, mode=0 at dout==0.
REQ-020 At a boundary event, the next dout SHALL follow REQ-031 (wrap or saturate); tc SHALL be 1 in the following cycle only; wrap_cnt SHALL increment by 1.
REQ-021 wrap_cnt SHALL saturate at all-ones and never roll over.
REQ-022 A mode change SHALL take effect on the same edge it is sampled, with no idle cycle.
REQ-023 Latency from input sampling to any output SHALL be exactly one clock; all outputs SHALL be registered.
REQ-024 Back-to-back boundary events (e.g. MAX_VAL=1, counting continuously) SHALL assert tc on consecutive cycles.

Reset
REQ-025 While rst=1 at a posedge, the block SHALL set dout=0, tc=0, wrap_cnt=0 and load_err=0, regardless of load and en.
REQ-026 A reset asserted mid-count or coincident with a boundary event SHALL suppress that event's tc and wrap_cnt increment.
REQ-027 The first edge after rst deasserts SHALL be processed normally.

Configuration
REQ-028 The block SHALL recognise the macro COUNTER_SATURATE_EN.
REQ-029 Without COUNTER_SATURATE_EN, an up boundary event SHALL take dout from MAX_VAL to 0 (wrap).
REQ-030 Without COUNTER_SATURATE_EN, a down boundary event SHALL take dout from 0 to MAX_VAL (wrap).
REQ-031 With COUNTER_SATURATE_EN, dout SHALL hold at MAX_VAL or 0 on a boundary event, while tc and wrap_cnt still behave per REQ-020, so saturation hits are counted.
REQ-032 COUNTER_SATURATE_EN SHALL be the only compile-time option; all other behaviour SHALL be identical in both builds.

Structure
REQ-033 Package counter_pkg SHALL hold the enum cnt_mode_e (CNT_DOWN=0, CNT_UP=1) and the default parameter constants.
REQ-034 The sub-module sat_event_counter SHALL implement the saturating WRAP_W-bit wrap_cnt, with inputs clk, rst and inc.
REQ-035 Next-value and boundary detection logic SHALL live in updown_mod_counter.

Verification (WIDTH=4, MAX_VAL=9, WRAP_W=3)
REQ-036 Reset, then load=1 with data_in=7 -> dout=7 next cycle, load_err=0, tc=0.
REQ-037 Load 8, then en=1, mode=1 for 2 cycles -> dout 9 then 0 (wrap build); tc=1 only in the cycle dout=0; wrap_cnt=1.
REQ-038 Load 0, then en=1, mode=0 -> dout=9 (wrap build) or dout=0 (COUNTER_SATURATE_EN build); tc=1 and wrap_cnt=1 in both builds.
REQ-039 load=1 with data_in=12 -> dout=9 and load_err=1 for one cycle; load=1, en=1, data_in=9 with dout=9 -> dout=9, tc=0.
REQ-040 Count continuously up through 9 boundary events -> wrap_cnt holds at 7.
REQ-041 Assert rst on the same edge as a boundary event -> dout=0, tc=0, wrap_cnt=0.
